// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer for the IF stage.
// This block owns the fetch PC. Each cycle the PC either advances by 4, takes a
// redirect, or holds. An EX redirect wins over a jal from ID. The PC is frozen
// on any front-end or pipeline stall. If an EX redirect arrives during an
// I-cache miss, it is latched and applied when the stall releases.
//
// state | meaning
// BOOT  | first cycle after reset, PC_o not yet a real fetch
// RUN   | normal fetch: advance, redirect, or hold on stall
// PEND  | EX redirect latched during I-cache miss, waiting for stall release
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_stall_i,
    input  logic        dcache_stall_i,
    input  logic        hazard_stall_i,
    input  logic        jal_ID_i,
    input  logic [31:0] jal_target_i,
    input  logic        branch_EX_i,
    input  logic [31:0] branch_target_i,
    input  logic        jalr_EX_i,
    input  logic [31:0] jalr_target_i,
    output logic [31:0] PC_o,
    output logic [31:0] PC_plus_o,
    output logic        fetch_valid_o,
    output logic        flush_IF_o,
    output logic        flush_ID_o,
    output logic        redir_pend_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pend_pc;

    logic        stall;
    logic        ex_red;
    logic [31:0] ex_tgt;
    logic        accept_ex;
    logic        accept_jal;
    logic        release_pend;

    // jalr targets are forced to halfword alignment, so bit 0 is never used.
    logic        unused_jalr_lsb;
    assign unused_jalr_lsb = jalr_target_i[0];

    // Decode the stall sources and the redirect sources for this cycle.
    always_comb begin
        stall        = icache_stall_i | dcache_stall_i | hazard_stall_i;
        ex_red       = jalr_EX_i | branch_EX_i;
        ex_tgt       = jalr_EX_i ? {jalr_target_i[31:1], 1'b0} : branch_target_i;
        accept_ex    = (state == RUN) && !stall && ex_red;
        accept_jal   = (state == RUN) && !stall && !ex_red && jal_ID_i;
        release_pend = (state == PEND) && !stall;
    end

    assign PC_o      = pc_q;
    assign PC_plus_o = pc_q + 32'd4;

    // Flushes fire in the same cycle the redirect is taken. A D-cache stall
    // freezes the whole pipe, so nothing is killed while it is asserted.
    always_comb begin
        flush_IF_o = 1'b0;
        flush_ID_o = 1'b0;
        if (!dcache_stall_i) begin
            flush_IF_o = accept_ex | accept_jal | release_pend;
            flush_ID_o = accept_ex | release_pend;
        end
    end

    // PC register and sequencing FSM, with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc_q          <= RESET_PC;
            pend_pc       <= '0;
            fetch_valid_o <= 1'b0;
            redir_pend_o  <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state         <= RUN;
                    fetch_valid_o <= 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        if (ex_red)
                            pc_q <= ex_tgt;
                        else if (jal_ID_i)
                            pc_q <= jal_target_i;
                        else
                            pc_q <= PC_plus_o;
                    end else if (icache_stall_i && ex_red) begin
                        pend_pc      <= ex_tgt;
                        state        <= PEND;
                        redir_pend_o <= 1'b1;
                    end
                end
                PEND: begin
                    // While PEND holds, later redirects come from the wrong path and are dropped.
                    if (!stall) begin
                        pc_q         <= pend_pc;
                        pend_pc      <= '0;
                        state        <= RUN;
                        redir_pend_o <= 1'b0;
                    end
                end
                default: begin
                    state         <= BOOT;
                    fetch_valid_o <= 1'b0;
                    redir_pend_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed testbench for fetch_pc_sequencer.
// Registered outputs are sampled 1ns after the rising edge. Combinational flushes
// are sampled 1ns after the inputs are driven.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_stall_i;
    logic        dcache_stall_i;
    logic        hazard_stall_i;
    logic        jal_ID_i;
    logic [31:0] jal_target_i;
    logic        branch_EX_i;
    logic [31:0] branch_target_i;
    logic        jalr_EX_i;
    logic [31:0] jalr_target_i;
    logic [31:0] PC_o;
    logic [31:0] PC_plus_o;
    logic        fetch_valid_o;
    logic        flush_IF_o;
    logic        flush_ID_o;
    logic        redir_pend_o;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    fetch_pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .icache_stall_i  (icache_stall_i),
        .dcache_stall_i  (dcache_stall_i),
        .hazard_stall_i  (hazard_stall_i),
        .jal_ID_i        (jal_ID_i),
        .jal_target_i    (jal_target_i),
        .branch_EX_i     (branch_EX_i),
        .branch_target_i (branch_target_i),
        .jalr_EX_i       (jalr_EX_i),
        .jalr_target_i   (jalr_target_i),
        .PC_o            (PC_o),
        .PC_plus_o       (PC_plus_o),
        .fetch_valid_o   (fetch_valid_o),
        .flush_IF_o      (flush_IF_o),
        .flush_ID_o      (flush_ID_o),
        .redir_pend_o    (redir_pend_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icache_stall_i  = 1'b0;
        dcache_stall_i  = 1'b0;
        hazard_stall_i  = 1'b0;
        jal_ID_i        = 1'b0;
        jal_target_i    = '0;
        branch_EX_i     = 1'b0;
        branch_target_i = '0;
        jalr_EX_i       = 1'b0;
        jalr_target_i   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        assert_cnt++; if (PC_o !== 32'h0) begin fail_cnt++; $display("FAIL reset_pc: got %h want %h", PC_o, 32'h0); end
        assert_cnt++; if (fetch_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid: got %b want 0", fetch_valid_o); end
        assert_cnt++; if ({flush_IF_o, flush_ID_o, redir_pend_o} !== 3'b000) begin fail_cnt++; $display("FAIL reset_flags: got %b want 000", {flush_IF_o, flush_ID_o, redir_pend_o}); end
        tick();
        assert_cnt++; if (PC_o !== 32'h0 || fetch_valid_o !== 1'b1) begin fail_cnt++; $display("FAIL boot_exit: got pc %h valid %b want 0 1", PC_o, fetch_valid_o); end
        tick();
        assert_cnt++; if (PC_o !== 32'h4) begin fail_cnt++; $display("FAIL seq_pc4: got %h want 4", PC_o); end
        tick();
        assert_cnt++; if (PC_o !== 32'h8) begin fail_cnt++; $display("FAIL seq_pc8: got %h want 8", PC_o); end
        assert_cnt++; if (PC_plus_o !== 32'hC) begin fail_cnt++; $display("FAIL seq_plus: got %h want c", PC_plus_o); end
    endtask

    task automatic test_redirect_priority();
        jal_ID_i = 1'b1; jal_target_i = 32'h40;
        #1;
        assert_cnt++; if ({flush_IF_o, flush_ID_o} !== 2'b10) begin fail_cnt++; $display("FAIL jal_flush: got %b want 10", {flush_IF_o, flush_ID_o}); end
        tick();
        clear_inputs();
        assert_cnt++; if (PC_o !== 32'h40) begin fail_cnt++; $display("FAIL jal_pc: got %h want 40", PC_o); end
        branch_EX_i = 1'b1; branch_target_i = 32'h100;
        jal_ID_i = 1'b1; jal_target_i = 32'h200;
        #1;
        assert_cnt++; if ({flush_IF_o, flush_ID_o} !== 2'b11) begin fail_cnt++; $display("FAIL branch_flush: got %b want 11", {flush_IF_o, flush_ID_o}); end
        tick();
        clear_inputs();
        assert_cnt++; if (PC_o !== 32'h100) begin fail_cnt++; $display("FAIL branch_over_jal: got %h want 100", PC_o); end
        jalr_EX_i = 1'b1; jalr_target_i = 32'h2A3;
        branch_EX_i = 1'b1; branch_target_i = 32'h400;
        tick();
        clear_inputs();
        assert_cnt++; if (PC_o !== 32'h2A2) begin fail_cnt++; $display("FAIL jalr_over_branch: got %h want 2a2", PC_o); end
    endtask

    task automatic test_hazard_hold();
        hazard_stall_i = 1'b1;
        jal_ID_i = 1'b1; jal_target_i = 32'h880;
        #1;
        assert_cnt++; if ({flush_IF_o, flush_ID_o} !== 2'b00) begin fail_cnt++; $display("FAIL hazard_flush: got %b want 00", {flush_IF_o, flush_ID_o}); end
        tick();
        clear_inputs();
        assert_cnt++; if (PC_o !== 32'h2A2 || redir_pend_o !== 1'b0) begin fail_cnt++; $display("FAIL hazard_hold: got pc %h pend %b want 2a2 0", PC_o, redir_pend_o); end
    endtask

    task automatic test_icache_pend();
        icache_stall_i = 1'b1;
        jalr_EX_i = 1'b1; jalr_target_i = 32'h301;
        #1;
        assert_cnt++; if ({flush_IF_o, flush_ID_o} !== 2'b00) begin fail_cnt++; $display("FAIL pend_latch_flush: got %b want 00", {flush_IF_o, flush_ID_o}); end
        tick();
        jalr_EX_i = 1'b0;
        assert_cnt++; if (redir_pend_o !== 1'b1 || PC_o !== 32'h2A2) begin fail_cnt++; $display("FAIL pend_set: got pend %b pc %h want 1 2a2", redir_pend_o, PC_o); end
        branch_EX_i = 1'b1; branch_target_i = 32'h700;
        jal_ID_i = 1'b1; jal_target_i = 32'h900;
        tick();
        branch_EX_i = 1'b0; jal_ID_i = 1'b0;
        tick();
        assert_cnt++; if (redir_pend_o !== 1'b1 || PC_o !== 32'h2A2) begin fail_cnt++; $display("FAIL pend_hold: got pend %b pc %h want 1 2a2", redir_pend_o, PC_o); end
        icache_stall_i = 1'b0;
        #1;
        assert_cnt++; if ({flush_IF_o, flush_ID_o} !== 2'b11) begin fail_cnt++; $display("FAIL pend_release_flush: got %b want 11", {flush_IF_o, flush_ID_o}); end
        tick();
        assert_cnt++; if (PC_o !== 32'h300 || redir_pend_o !== 1'b0) begin fail_cnt++; $display("FAIL pend_release_pc: got pc %h pend %b want 300 0", PC_o, redir_pend_o); end
    endtask

    task automatic test_dcache_freeze();
        dcache_stall_i = 1'b1;
        branch_EX_i = 1'b1; branch_target_i = 32'h180;
        #1;
        assert_cnt++; if ({flush_IF_o, flush_ID_o} !== 2'b00) begin fail_cnt++; $display("FAIL dcache_flush: got %b want 00", {flush_IF_o, flush_ID_o}); end
        tick();
        tick();
        assert_cnt++; if (PC_o !== 32'h300 || redir_pend_o !== 1'b0) begin fail_cnt++; $display("FAIL dcache_hold: got pc %h pend %b want 300 0", PC_o, redir_pend_o); end
        dcache_stall_i = 1'b0;
        #1;
        assert_cnt++; if ({flush_IF_o, flush_ID_o} !== 2'b11) begin fail_cnt++; $display("FAIL dcache_release_flush: got %b want 11", {flush_IF_o, flush_ID_o}); end
        tick();
        branch_EX_i = 1'b0;
        #1;
        assert_cnt++; if (PC_o !== 32'h180 || {flush_IF_o, flush_ID_o} !== 2'b00) begin fail_cnt++; $display("FAIL dcache_after: got pc %h flush %b want 180 00", PC_o, {flush_IF_o, flush_ID_o}); end
        tick();
        assert_cnt++; if (PC_o !== 32'h184) begin fail_cnt++; $display("FAIL dcache_seq: got %h want 184", PC_o); end
    endtask

    task automatic test_wrap();
        jal_ID_i = 1'b1; jal_target_i = 32'hFFFF_FFFC;
        tick();
        jal_ID_i = 1'b0;
        assert_cnt++; if (PC_o !== 32'hFFFF_FFFC || PC_plus_o !== 32'h0) begin fail_cnt++; $display("FAIL wrap_plus: got pc %h plus %h want fffffffc 0", PC_o, PC_plus_o); end
        tick();
        assert_cnt++; if (PC_o !== 32'h0) begin fail_cnt++; $display("FAIL wrap_pc: got %h want 0", PC_o); end
    endtask

    task automatic test_reset_in_pend();
        tick();
        icache_stall_i = 1'b1;
        branch_EX_i = 1'b1; branch_target_i = 32'h500;
        tick();
        branch_EX_i = 1'b0;
        assert_cnt++; if (redir_pend_o !== 1'b1) begin fail_cnt++; $display("FAIL rstpend_set: got %b want 1", redir_pend_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        icache_stall_i = 1'b0;
        assert_cnt++; if (PC_o !== 32'h0 || redir_pend_o !== 1'b0 || fetch_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL rstpend_reset: got pc %h pend %b valid %b want 0 0 0", PC_o, redir_pend_o, fetch_valid_o); end
        tick();
        tick();
        assert_cnt++; if (PC_o !== 32'h4) begin fail_cnt++; $display("FAIL rstpend_discard: got %h want 4", PC_o); end
    endtask

    initial begin
        test_reset();
        test_redirect_priority();
        test_hazard_hold();
        test_icache_pend();
        test_dcache_freeze();
        test_wrap();
        test_reset_in_pend();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
